// File: rtl/noc_switch_allocator_pkg.sv
// Shared types and helpers for the wormhole switch allocator.
package noc_switch_allocator_pkg;

    localparam int NUM_PORTS = 5;

    // Flit position within a packet, as carried on the input buffer head.
    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_Data_Label;

    // Router port numbering.
    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_Id;

    // Per-output ownership state.
    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    // Flits that may open a packet (and so take part in arbitration).
    function automatic logic is_head(input flit_Data_Label l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    // Flits that may only follow a HEAD on an already-owned output.
    function automatic logic is_body_tail(input flit_Data_Label l);
        return (l == BODY) || (l == TAIL);
    endfunction

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping N-1 -> 0. Pointer storage lives in the instantiating block.
module rr_arbiter #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Scan requesters starting at ptr and pick the first one found.
    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator for one mesh router: per-output round-robin on
// packet heads, output lock until TAIL, and credit-based flow control.
//
// Handshake: in_valid[i] means input i presents a flit; in_grant[i] is the
// same-cycle accept. A flit moves exactly when in_valid[i] && in_grant[i];
// in_grant is never raised without in_valid and in_valid must not depend on
// in_grant. out_valid[o]/xbar_sel[o] describe that same transfer on output o.
module noc_switch_allocator
    import noc_switch_allocator_pkg::*;
#(
    parameter int NPORTS    = NUM_PORTS,
    parameter int BUF_DEPTH = 4,
    localparam int PW = $clog2(NPORTS),
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    in_valid,
    input  logic [2*NPORTS-1:0]  in_label,
    input  logic [NPORTS*PW-1:0] in_out_port,
    output logic [NPORTS-1:0]    in_grant,
    output logic [NPORTS-1:0]    out_valid,
    output logic [NPORTS*PW-1:0] xbar_sel,
    input  logic [NPORTS-1:0]    credit_ret,
    output logic                 proto_err,
    output logic [NPORTS-1:0]    dbg_locked,
    output logic [NPORTS*PW-1:0] dbg_owner,
    output logic [NPORTS*PW-1:0] dbg_rr_ptr,
    output logic [NPORTS*CW-1:0] dbg_credits
);

    flit_Data_Label    lbl      [NPORTS];
    logic [PW-1:0]     dst      [NPORTS];
    logic [NPORTS-1:0] head_req [NPORTS];
    logic [NPORTS-1:0] arb_gnt  [NPORTS];
    logic [PW-1:0]     arb_idx  [NPORTS];

    out_state_e        state_q  [NPORTS];
    out_state_e        state_d  [NPORTS];
    logic [PW-1:0]     owner_q  [NPORTS];
    logic [PW-1:0]     owner_d  [NPORTS];
    logic [PW-1:0]     rr_q     [NPORTS];
    logic [PW-1:0]     rr_d     [NPORTS];
    logic [CW-1:0]     cred_q   [NPORTS];
    logic [CW-1:0]     cred_d   [NPORTS];

    logic [NPORTS-1:0] win_valid;
    logic [PW-1:0]     win_idx  [NPORTS];
    logic [NPORTS-1:0] win_lock;
    logic [NPORTS-1:0] win_unlock;
    logic [NPORTS-1:0] cred_ovf;
    logic              err_now;
    logic              proto_err_q;

    // Unpack the flat per-input buses into label and destination arrays.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            lbl[i] = flit_Data_Label'(in_label[2*i +: 2]);
            dst[i] = in_out_port[PW*i +: PW];
        end
    end

    // Head flits contend for an output; a HEAD toward an output the same
    // input already owns is a protocol error and never competes.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                head_req[o][i] = in_valid[i] && (dst[i] == PW'(o)) && is_head(lbl[i])
                                 && !((state_q[o] == OUT_LOCKED) && (owner_q[o] == PW'(i)));
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NPORTS; g++) begin : g_arb
            rr_arbiter #(.N(NPORTS)) u_arb (
                .req     (head_req[g]),
                .ptr     (rr_q[g]),
                .gnt     (arb_gnt[g]),
                .gnt_idx (arb_idx[g])
            );
        end
    endgenerate

    // Choose the winner per output: arbiter result when idle, only the
    // owner's BODY/TAIL when locked, nothing without credit or in reset.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            win_valid[o]  = 1'b0;
            win_idx[o]    = '0;
            win_lock[o]   = 1'b0;
            win_unlock[o] = 1'b0;
            if (!rst && (cred_q[o] != '0)) begin
                if (state_q[o] == OUT_IDLE) begin
                    if (|arb_gnt[o]) begin
                        win_valid[o] = 1'b1;
                        win_idx[o]   = arb_idx[o];
                        win_lock[o]  = (lbl[arb_idx[o]] == HEAD);
                    end
                end else begin
                    if (in_valid[owner_q[o]] && (dst[owner_q[o]] == PW'(o))
                        && is_body_tail(lbl[owner_q[o]])) begin
                        win_valid[o]  = 1'b1;
                        win_idx[o]    = owner_q[o];
                        win_unlock[o] = (lbl[owner_q[o]] == TAIL);
                    end
                end
            end
        end
    end

    // Drive crossbar selects and the matching input pops from the winners.
    always_comb begin
        out_valid = win_valid;
        in_grant  = '0;
        xbar_sel  = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (win_valid[o]) begin
                xbar_sel[PW*o +: PW] = win_idx[o];
                in_grant[win_idx[o]] = 1'b1;
            end
        end
    end

    // Flag BODY/TAIL without ownership and HEAD/HEADTAIL while owning.
    always_comb begin
        logic owns;
        owns    = 1'b0;
        err_now = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int o = 0; o < NPORTS; o++) begin
                if (in_valid[i] && (dst[i] == PW'(o))) begin
                    owns = (state_q[o] == OUT_LOCKED) && (owner_q[o] == PW'(i));
                    if (is_body_tail(lbl[i]) && !owns) err_now = 1'b1;
                    if (is_head(lbl[i]) && owns)       err_now = 1'b1;
                end
            end
        end
    end

    // Credit bookkeeping: subtract sends, add returns, saturate at BUF_DEPTH.
    always_comb begin
        logic [CW:0] sum;
        sum = '0;
        for (int o = 0; o < NPORTS; o++) begin
            sum = {1'b0, cred_q[o]} + (CW+1)'(credit_ret[o]) - (CW+1)'(out_valid[o]);
            if (sum > (CW+1)'(BUF_DEPTH)) begin
                cred_d[o]   = CW'(BUF_DEPTH);
                cred_ovf[o] = 1'b1;
            end else begin
                cred_d[o]   = sum[CW-1:0];
                cred_ovf[o] = 1'b0;
            end
        end
    end

    // Per-output lock FSM next state; pointer advances only on idle grants.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            if (win_valid[o]) begin
                if (state_q[o] == OUT_IDLE) begin
                    rr_d[o] = (win_idx[o] == PW'(NPORTS-1)) ? '0 : win_idx[o] + PW'(1);
                    if (win_lock[o]) begin
                        state_d[o] = OUT_LOCKED;
                        owner_d[o] = win_idx[o];
                    end
                end else if (win_unlock[o]) begin
                    state_d[o] = OUT_IDLE;
                end
            end
        end
    end

    // State registers; reset drops every lock immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
                cred_q[o]  <= CW'(BUF_DEPTH);
            end
            proto_err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
                cred_q[o]  <= cred_d[o];
            end
            proto_err_q <= proto_err_q | err_now | (|cred_ovf);
        end
    end

    // Expose the per-output state for observation.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            dbg_locked[o]           = (state_q[o] == OUT_LOCKED);
            dbg_owner[PW*o +: PW]   = owner_q[o];
            dbg_rr_ptr[PW*o +: PW]  = rr_q[o];
            dbg_credits[CW*o +: CW] = cred_q[o];
        end
    end

    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Self-checking bench for noc_switch_allocator: directed scenarios followed
// by constrained-random traffic, all compared against a packet-level model.
module tb_noc_switch_allocator;
    import noc_switch_allocator_pkg::*;

    localparam int N  = 5;
    localparam int BD = 4;
    localparam int PW = 3;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [2*N-1:0]  in_label;
    logic [N*PW-1:0] in_out_port;
    logic [N-1:0]    in_grant;
    logic [N-1:0]    out_valid;
    logic [N*PW-1:0] xbar_sel;
    logic [N-1:0]    credit_ret;
    logic            proto_err;
    logic [N-1:0]    dbg_locked;
    logic [N*PW-1:0] dbg_owner;
    logic [N*PW-1:0] dbg_rr_ptr;
    logic [N*CW-1:0] dbg_credits;

    int checks = 0;
    int errors = 0;

    // Reference model: owner per output (-1 = free), pointer, credits.
    int m_owner [N];
    int m_ptr   [N];
    int m_cred  [N];
    bit m_err;

    logic [N-1:0]    e_grant;
    logic [N-1:0]    e_ov;
    logic [N*PW-1:0] e_sel;
    int              e_win [N];
    bit              e_err_now;

    // Observed same-cycle outputs of the most recent step.
    logic [N-1:0]    s_grant;
    logic [N-1:0]    s_ov;
    logic [N*PW-1:0] s_sel;

    logic [PW-1:0]   exp_q[$];

    noc_switch_allocator #(.NPORTS(N), .BUF_DEPTH(BD)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_label    (in_label),
        .in_out_port (in_out_port),
        .in_grant    (in_grant),
        .out_valid   (out_valid),
        .xbar_sel    (xbar_sel),
        .credit_ret  (credit_ret),
        .proto_err   (proto_err),
        .dbg_locked  (dbg_locked),
        .dbg_owner   (dbg_owner),
        .dbg_rr_ptr  (dbg_rr_ptr),
        .dbg_credits (dbg_credits)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input int i, input logic v, input logic [1:0] l, input logic [2:0] d);
        in_valid[i]          = v;
        in_label[2*i +: 2]   = l;
        in_out_port[PW*i +: PW] = d;
    endtask

    task automatic clear_in();
        in_valid    = '0;
        in_label    = '0;
        in_out_port = '0;
        credit_ret  = '0;
    endtask

    // ---------------- reference model ----------------
    function automatic int lbl_of(input int i);
        return int'(in_label[2*i +: 2]);
    endfunction

    function automatic int dst_of(input int i);
        return int'(in_out_port[PW*i +: PW]);
    endfunction

    function automatic bit is_hd(input int l);
        return (l == int'(HEAD)) || (l == int'(HEADTAIL));
    endfunction

    function automatic bit is_bt(input int l);
        return (l == int'(BODY)) || (l == int'(TAIL));
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
            m_cred[o]  = BD;
        end
        m_err = 1'b0;
    endtask

    task automatic model_eval();
        e_grant   = '0;
        e_ov      = '0;
        e_sel     = '0;
        e_err_now = 1'b0;
        for (int o = 0; o < N; o++) begin
            int win;
            win = -1;
            if (m_cred[o] > 0) begin
                if (m_owner[o] < 0) begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr[o] + k) % N;
                        if (win < 0 && in_valid[c] && dst_of(c) == o && is_hd(lbl_of(c))) win = c;
                    end
                end else begin
                    int w;
                    w = m_owner[o];
                    if (in_valid[w] && dst_of(w) == o && is_bt(lbl_of(w))) win = w;
                end
            end
            e_win[o] = win;
            if (win >= 0) begin
                e_ov[o]              = 1'b1;
                e_sel[PW*o +: PW]    = PW'(win);
                e_grant[win]         = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && dst_of(i) < N) begin
                if (is_bt(lbl_of(i)) && m_owner[dst_of(i)] != i) e_err_now = 1'b1;
                if (is_hd(lbl_of(i)) && m_owner[dst_of(i)] == i) e_err_now = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        for (int o = 0; o < N; o++) begin
            int c;
            if (e_ov[o]) begin
                if (m_owner[o] < 0) begin
                    m_ptr[o] = (e_win[o] + 1) % N;
                    if (lbl_of(e_win[o]) == int'(HEAD)) m_owner[o] = e_win[o];
                end else if (lbl_of(e_win[o]) == int'(TAIL)) begin
                    m_owner[o] = -1;
                end
            end
            c = m_cred[o] - int'(e_ov[o]) + int'(credit_ret[o]);
            if (c > BD) begin
                c     = BD;
                m_err = 1'b1;
            end
            m_cred[o] = c;
        end
        if (e_err_now) m_err = 1'b1;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check_state(input string tag);
        logic [N*CW-1:0] ec;
        logic [N*PW-1:0] ep;
        logic [N*PW-1:0] eo;
        logic [N*PW-1:0] ao;
        logic [N-1:0]    el;
        ec = '0; ep = '0; eo = '0; ao = '0; el = '0;
        for (int o = 0; o < N; o++) begin
            ec[CW*o +: CW] = CW'(m_cred[o]);
            ep[PW*o +: PW] = PW'(m_ptr[o]);
            if (m_owner[o] >= 0) begin
                el[o]          = 1'b1;
                eo[PW*o +: PW] = PW'(m_owner[o]);
                ao[PW*o +: PW] = dbg_owner[PW*o +: PW];
            end
        end
        check({tag, ".proto_err"}, 32'(proto_err), 32'(m_err));
        check({tag, ".credits"},   32'(dbg_credits), 32'(ec));
        check({tag, ".rr_ptr"},    32'(dbg_rr_ptr), 32'(ep));
        check({tag, ".locked"},    32'(dbg_locked), 32'(el));
        check({tag, ".owner"},     32'(ao), 32'(eo));
    endtask

    // One clock cycle: check combinational grants, clock, check state.
    task automatic step(input string tag);
        #1;
        model_eval();
        s_grant = in_grant;
        s_ov    = out_valid;
        s_sel   = xbar_sel;
        check({tag, ".in_grant"},  32'(in_grant), 32'(e_grant));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, ".xbar_sel"},  32'(xbar_sel), 32'(e_sel));
        @(posedge clk);
        model_update();
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".async_grant"},  32'(in_grant), 32'd0);
        check({tag, ".async_valid"},  32'(out_valid), 32'd0);
        check({tag, ".async_sel"},    32'(xbar_sel), 32'd0);
        check({tag, ".async_locked"}, 32'(dbg_locked), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_state(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        model_reset();
        do_reset("reset");
        check("reset.credits_all", 32'(dbg_credits), 32'(15'o44444));
        check("reset.rr_all",      32'(dbg_rr_ptr), 32'd0);

        // 1: single HEADTAIL, input 2 -> output 1
        set_in(2, 1'b1, HEADTAIL, 3'd1);
        step("t1");
        check("t1.grant2", 32'(s_grant), 32'b00100);
        check("t1.ov1",    32'(s_ov), 32'b00010);
        check("t1.sel1",   32'(s_sel[PW*1 +: PW]), 32'd2);
        check("t1.cred1",  32'(dbg_credits[CW*1 +: CW]), 32'd3);
        check("t1.ptr1",   32'(dbg_rr_ptr[PW*1 +: PW]), 32'd3);
        clear_in();

        // 2: lock held against a competing HEAD until TAIL
        set_in(0, 1'b1, HEAD, 3'd2);
        set_in(3, 1'b1, HEAD, 3'd2);
        credit_ret[2] = 1'b1;
        step("t2.head");
        check("t2.win0", 32'(s_grant), 32'b00001);
        set_in(0, 1'b1, BODY, 3'd2);
        step("t2.body1");
        check("t2.block1", 32'(s_grant), 32'b00001);
        step("t2.body2");
        check("t2.block2", 32'(s_grant), 32'b00001);
        set_in(0, 1'b1, TAIL, 3'd2);
        step("t2.tail");
        check("t2.block3", 32'(s_grant), 32'b00001);
        set_in(0, 1'b0, HEAD, 3'd0);
        step("t2.next");
        check("t2.win3", 32'(s_grant), 32'b01000);
        check("t2.sel3", 32'(s_sel[PW*2 +: PW]), 32'd3);
        set_in(3, 1'b1, TAIL, 3'd2);
        step("t2.tail3");
        clear_in();

        // 3: credit exhaustion and recovery on output 4
        set_in(1, 1'b1, HEADTAIL, 3'd4);
        for (int k = 0; k < 4; k++) begin
            step("t3.burst");
            check("t3.burst_ov", 32'(s_ov[4]), 32'd1);
        end
        step("t3.empty");
        check("t3.stall", 32'(s_ov[4]), 32'd0);
        credit_ret[4] = 1'b1;
        step("t3.ret");
        check("t3.ret_stall", 32'(s_ov[4]), 32'd0);
        step("t3.sendret1");
        check("t3.resume", 32'(s_ov[4]), 32'd1);
        step("t3.sendret2");
        check("t3.cred_const", 32'(dbg_credits[CW*4 +: CW]), 32'd1);
        clear_in();
        credit_ret[4] = 1'b1;
        repeat (3) step("t3.refill");
        check("t3.cred_full", 32'(dbg_credits[CW*4 +: CW]), 32'd4);
        clear_in();

        // 4: rotation among inputs 0, 1, 4 on output 0
        set_in(0, 1'b1, HEADTAIL, 3'd0);
        set_in(1, 1'b1, HEADTAIL, 3'd0);
        set_in(4, 1'b1, HEADTAIL, 3'd0);
        credit_ret[0] = 1'b1;
        exp_q = {3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd4};
        for (int k = 0; k < 6; k++) begin
            logic [PW-1:0] want;
            want = exp_q.pop_front();
            step("t4.rot");
            check("t4.order", 32'(s_sel[PW*0 +: PW]), 32'(want));
        end
        clear_in();

        // 5: protocol errors
        set_in(1, 1'b1, BODY, 3'd3);
        step("t5.body");
        check("t5.no_grant", 32'(s_grant), 32'd0);
        check("t5.err", 32'(proto_err), 32'd1);
        clear_in();
        repeat (2) step("t5.idle");
        check("t5.sticky", 32'(proto_err), 32'd1);
        do_reset("t5.rst");
        check("t5.err_clr", 32'(proto_err), 32'd0);
        credit_ret[3] = 1'b1;
        step("t5.ovf");
        check("t5.ovf_err",  32'(proto_err), 32'd1);
        check("t5.ovf_cred", 32'(dbg_credits[CW*3 +: CW]), 32'd4);
        clear_in();
        do_reset("t5.rst2");

        // 6: reset in the middle of a packet
        set_in(0, 1'b1, HEAD, 3'd1);
        step("t6.head");
        set_in(0, 1'b1, BODY, 3'd1);
        step("t6.body");
        do_reset("t6.rst");
        set_in(0, 1'b0, HEAD, 3'd0);
        set_in(3, 1'b1, HEAD, 3'd1);
        step("t6.newhead");
        check("t6.grant3", 32'(s_grant), 32'b01000);
        check("t6.sel3",   32'(s_sel[PW*1 +: PW]), 32'd3);
        set_in(3, 1'b1, TAIL, 3'd1);
        step("t6.tail");
        clear_in();

        // Random wormhole traffic with spare credit returns
        do_reset("rnd.rst");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                int own;
                own = -1;
                for (int o = 0; o < N; o++) if (m_owner[o] == i) own = o;
                if (own >= 0)
                    set_in(i, ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 1) != 0) ? BODY : TAIL, 3'(own));
                else
                    set_in(i, ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 1) != 0) ? HEAD : HEADTAIL,
                           3'($urandom_range(0, N-1)));
            end
            for (int o = 0; o < N; o++)
                credit_ret[o] = (m_cred[o] < BD) ? 1'($urandom_range(0, 1)) : 1'b0;
            step("rnd");
        end
        clear_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
